// File: rtl/bus_master.sv
// bus_master: single-outstanding request/response bus master driving an address decoder and up to 7 devices.
// Optional ack timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [15:0]   req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [15:0]   bus_addr,
    output logic [15:0]   bus_wdata,
    input  logic          bus_hit,
    input  logic [2:0]    bus_did,
    input  logic [6:0]    dev_ack,
    input  logic [111:0]  dev_rdata
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    state_t        r_state;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [15:0]   r_rsp_rdata;
    logic          r_bus_rd;
    logic          r_bus_wr;
    logic [15:0]   r_bus_addr;
    logic [15:0]   r_bus_wdata;

    // Device id 7 maps to a padded zero slot so it can never ack or return data.
    logic [7:0]    w_ack_vec;
    logic [127:0]  w_rdata_vec;
    logic          w_miss;
    logic          w_ack;
    logic          w_timeout;
    logic [15:0]   w_sel_rdata;

    assign w_ack_vec   = {1'b0, dev_ack};
    assign w_rdata_vec = {16'h0000, dev_rdata};
    assign w_miss      = !bus_hit || bus_did == 3'd7;
    assign w_ack       = !w_miss && w_ack_vec[bus_did];
    assign w_sel_rdata = w_rdata_vec[{bus_did, 4'b0000} +: 16];

`ifdef BUS_TIMEOUT_EN
    logic [7:0]    r_cnt;
    // An ack arriving on the last allowed cycle wins over the timeout.
    assign w_timeout = !w_ack && r_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
    assign w_timeout = 1'b0;
`endif

    // Main FSM: accept one request, run it on the bus, hold the response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 16'h0000;
            r_bus_rd    <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_addr  <= 16'h0000;
            r_bus_wdata <= 16'h0000;
`ifdef BUS_TIMEOUT_EN
            r_cnt       <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_bus_addr  <= req_addr;
                        r_bus_wdata <= req_wdata;
                        r_bus_rd    <= !req_we;
                        r_bus_wr    <= req_we;
                        r_state     <= BUS;
`ifdef BUS_TIMEOUT_EN
                        r_cnt       <= 8'h00;
`endif
                    end
                end
                BUS: begin
                    if (w_miss || w_ack || w_timeout) begin
                        r_bus_rd    <= 1'b0;
                        r_bus_wr    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_ack;
                        r_rsp_rdata <= (w_ack && r_bus_rd) ? w_sel_rdata : 16'h0000;
                        r_state     <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 8'h01;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign bus_rd    = r_bus_rd;
    assign bus_wr    = r_bus_wr;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: randomized scoreboard bench for bus_master with a transaction-level device model.
module tb_bus_master;
`ifdef BUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 16;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_rdata;
    logic bus_rd, bus_wr;
    logic [15:0] bus_addr, bus_wdata;
    logic bus_hit = 1'b0;
    logic [2:0] bus_did = '0;
    logic [6:0] dev_ack = '0;
    logic [111:0] dev_rdata = '0;

    bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_hit(bus_hit), .bus_did(bus_did), .dev_ack(dev_ack), .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          rcyc;
        int          stall;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic timeout_fail(input string name);
        chk(name, 32'd1, 32'd0);
        finish_test();
    endtask

    // Current transaction as seen by the device model.
    logic t_we = 1'b0, t_hit = 1'b0;
    logic [2:0] t_did = '0;
    logic [15:0] t_addr = '0, t_wdata = '0, t_rdata = '0;
    int t_ack = 0;
    int bus_cnt = 0;

    // Device model: decoder result, delayed ack from the addressed device, noise elsewhere.
    always @(negedge clk) begin
        logic [6:0] noise;
        noise = 7'($urandom);
        if (rst_n && (bus_rd || bus_wr)) begin
            bus_cnt = bus_cnt + 1;
            chk("bus_rd", {31'd0, bus_rd}, {31'd0, !t_we});
            chk("bus_wr", {31'd0, bus_wr}, {31'd0, t_we});
            chk("bus_addr", {16'd0, bus_addr}, {16'd0, t_addr});
            chk("bus_wdata", {16'd0, bus_wdata}, {16'd0, t_wdata});
            chk("req_ready_in_bus", {31'd0, req_ready}, 32'd0);
        end else begin
            bus_cnt = 0;
        end
        if (t_did != 3'd7) noise[t_did] = (bus_rd || bus_wr) && bus_cnt >= t_ack + 1;
        dev_ack = noise;
        bus_hit = t_hit;
        bus_did = t_did;
        for (int i = 0; i < 7; i++) dev_rdata[16*i +: 16] = 16'($urandom);
        if (t_did != 3'd7) dev_rdata[16*t_did +: 16] = t_rdata;
    end

    // Monitor: pops the expected response when it appears and checks it stays put while stalled.
    bit in_rsp = 0;
    int stall_left = 0;
    exp_t cur;
    logic [15:0] prev_rdata;
    logic prev_err;
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (!in_rsp) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                    stall_left = 0;
                end else begin
                    cur = q.pop_front();
                    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, cur.rdata});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                    chk("rsp_cycle", cyc, cur.rcyc);
                    stall_left = cur.stall;
                end
                in_rsp = 1;
            end else begin
                chk("rsp_rdata_stable", {16'd0, rsp_rdata}, {16'd0, prev_rdata});
                chk("rsp_err_stable", {31'd0, rsp_err}, {31'd0, prev_err});
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            chk("bus_idle_in_resp", {30'd0, bus_rd, bus_wr}, 32'd0);
            prev_rdata = rsp_rdata;
            prev_err = rsp_err;
            rsp_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end else begin
            in_rsp = 0;
            rsp_ready = 1'($urandom);
        end
    end

    // Reference outcome of one transaction from the protocol rules.
    function automatic int bus_cycles(input logic hit, input logic [2:0] did, input int ack);
        if (!hit || did == 3'd7) return 1;
`ifdef BUS_TIMEOUT_EN
        if (ack + 1 > TO) return TO;
`endif
        return ack + 1;
    endfunction

    task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic hit, input logic [2:0] did, input int ack,
                       input logic [15:0] rdata, input int stall);
        exp_t e;
        int n;
        int w;
        t_we = we; t_addr = addr; t_wdata = wdata; t_hit = hit; t_did = did;
        t_ack = ack; t_rdata = rdata;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready) begin
            @(negedge clk);
            if (++w > 300) timeout_fail("accept_timeout");
        end
        n = bus_cycles(hit, did, ack);
        e.err = !hit || did == 3'd7 || ack + 1 > n;
        e.rdata = (e.err || we) ? 16'h0000 : rdata;
        e.rcyc = cyc + 1 + n;
        e.stall = stall;
        q.push_back(e);
        @(negedge clk);
        w = 0;
        while (!rsp_valid) begin
            req_valid = 1'($urandom); req_we = 1'($urandom);
            req_addr = 16'($urandom); req_wdata = 16'($urandom);
            @(negedge clk);
            if (++w > 300) timeout_fail("rsp_timeout");
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_bus_rdwr", {30'd0, bus_rd, bus_wr}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_bus_wdata", {16'd0, bus_wdata}, 32'd0);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

        txn(1'b0, 16'h1ABC, 16'h0000, 1'b1, 3'd1, 0, 16'hBEEF, 0);
        txn(1'b1, 16'h6000, 16'h1234, 1'b1, 3'd6, 2, 16'h5555, 1);
        txn(1'b0, 16'h7000, 16'h0000, 1'b0, 3'd3, 0, 16'hAAAA, 0);
        txn(1'b0, 16'h7F00, 16'h0000, 1'b1, 3'd7, 0, 16'hAAAA, 0);
        txn(1'b0, 16'h2222, 16'h0000, 1'b1, 3'd2, 1, 16'hC0DE, 5);
        txn(1'b0, 16'h3000, 16'h0000, 1'b1, 3'd0, TO - 1, 16'h0F0F, 0);
        txn(1'b1, 16'h4000, 16'h9999, 1'b1, 3'd4, 100, 16'h0000, 2);
        txn(1'b0, 16'h5000, 16'h0000, 1'b1, 3'd5, 0, 16'hFFFF, 0);
        for (int i = 0; i < 25; i++)
            txn(1'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 5) != 0),
                3'($urandom), $urandom_range(0, 6), 16'($urandom), $urandom_range(0, 3));

        w = 0;
        req_valid = 1'b0;
        while (q.size() != 0 || rsp_valid) begin
            @(negedge clk);
            if (++w > 300) timeout_fail("drain_timeout");
        end

        t_we = 1'b0; t_addr = 16'h1234; t_wdata = 16'h0; t_hit = 1'b1; t_did = 3'd2;
        t_ack = 50; t_rdata = 16'h7777;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; req_wdata = 16'h0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_bus_before_reset", {31'd0, bus_rd}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_rsp_after_abort", {31'd0, rsp_valid}, 32'd0);
        chk("idle_after_abort", {31'd0, req_ready}, 32'd1);
        finish_test();
    end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of cycles waited for a device ack before abort (range 2..255).
REQ-002 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit, upstream request present.
REQ-005 SHALL have port req_ready, output, 1 bit, bus_master can accept a request.
REQ-006 SHALL have ports req_we (input, 1 bit, 1=write), req_addr (input, 16 bits) and req_wdata (input, 16 bits).
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 16) and rsp_err (output, 1), forming the response channel.
REQ-008 SHALL have ports bus_rd, bus_wr (outputs, 1 each), bus_addr and bus_wdata (outputs, 16 each), which drive the address decoder and devices.
REQ-009 SHALL have ports bus_hit (input, 1) and bus_did (input, 3), the decoder result for the current bus_addr.
REQ-010 SHALL have ports dev_ack (input, 7 bits, bit n = device n) and dev_rdata (input, 112 bits, device n at bits [16n+15:16n]).

Function
REQ-011 SHALL implement FSM states IDLE, BUS, RESP.
REQ-012 IDLE: SHALL drive req_ready=1; on req_valid=1, SHALL latch we/addr/wdata and go to BUS next cycle.
REQ-013 BUS: SHALL drive bus_addr/bus_wdata from the latch, with bus_rd=!we and bus_wr=we; bus_rd and bus_wr SHALL never both be 1.
REQ-014 BUS with bus_hit=0: SHALL go to RESP with rsp_err=1, rsp_rdata=0, on the first BUS cycle.
REQ-015 BUS with bus_hit=1 and dev_ack[bus_did]=1: SHALL go to RESP with rsp_err=0; for a read, rsp_rdata SHALL be that device's dev_rdata slice; for a write, rsp_rdata SHALL be 0.
REQ-016 dev_ack bits other than dev_ack[bus_did] SHALL be ignored.
REQ-017 bus_did=7 with bus_hit=1 SHALL be treated as a miss (REQ-014).
REQ-018 RESP: SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready=1, then go to IDLE; bus_rd and bus_wr SHALL be 0.
REQ-019 Minimum latency: request accepted in cycle N with ack in cycle N+1 SHALL give rsp_valid in cycle N+2.
REQ-020 req_ready SHALL be 0 in BUS and RESP; requests are not pipelined.
REQ-021 An ack and a timeout in the same cycle SHALL resolve as ack.

Reset
REQ-022 While rst_n=0, the FSM SHALL go to IDLE asynchronously.
REQ-023 While rst_n=0, outputs SHALL be: req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, bus_rd=0, bus_wr=0, bus_addr=0, bus_wdata=0.
REQ-024 req_ready SHALL become 1 in the first cycle after rst_n deasserts.
REQ-025 A reset during BUS or RESP SHALL abort the transaction with no response.

Configuration
REQ-026 With BUS_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-027 With BUS_TIMEOUT_EN defined, after TIMEOUT_CYCLES BUS cycles without ack, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-028 With BUS_TIMEOUT_EN undefined, no counter SHALL exist and BUS SHALL wait indefinitely for ack.

Verification
REQ-029 Read 0x1ABC, hit=1, did=1, dev_ack[1] set the next cycle, dev_rdata slice 1=0xBEEF -> rsp_valid 2 cycles after accept, rdata=0xBEEF, err=0.
REQ-030 Write 0x6000 wdata=0x1234, did=6, ack after 3 cycles -> bus_wr=1 and bus_rd=0 for 3 cycles, then rsp err=0, rdata=0.
REQ-031 Read 0x7000 with hit=0 -> rsp_err=1 one cycle after BUS entry, and no dev_ack is required.
REQ-032 BUS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and no ack -> rsp_err=1 after exactly 4 BUS cycles; without the macro, still waiting at 100 cycles.
REQ-033 rsp_ready held 0 for 5 cycles -> rsp stays valid and stable, req_ready=0, and req_valid is ignored.
REQ-034 rst_n pulsed low mid-BUS -> all outputs clear immediately, and no rsp_valid follows.
